// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples external BCLK/LRCLK/DATA on CLK_IN and recovers
// stereo PCM pairs, with slot-length checking and BCLK-loss lock detection.
module i2s_slave_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int BITS_PER_CH = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                  CLK_IN,
  input  logic                  reset_n,
  input  logic                  bclk_in,
  input  logic                  lrclk_in,
  input  logic                  data_in,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  locked
);

  localparam int              TW           = $clog2(TIMEOUT + 1);
  localparam logic [5:0]      SLOT_LAST    = 6'(BITS_PER_CH - 1);
  localparam logic [5:0]      CAP_LIMIT    = 6'(DATA_WIDTH);
  localparam logic [5:0]      CNT_MAX      = 6'd63;
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   TIMEOUT_SAT  = TW'(TIMEOUT);
  localparam logic [TW-1:0]   TIMEOUT_ONE  = TW'(1);

  // UNALIGNED: no LR edge seen yet; ALIGNED: slots are checked; HAVE_LEFT: left word held
  typedef enum logic [1:0] {
    UNALIGNED = 2'd0,
    ALIGNED   = 2'd1,
    HAVE_LEFT = 2'd2
  } link_state_t;

  link_state_t state, state_next;

  logic bclk_s1, bclk_s2, bclk_s3;
  logic lr_s1, lr_s;
  logic data_s1, data_s;

  logic                  rise;
  logic                  lr_change;
  logic                  slot_ok;
  logic                  timeout_hit;
  logic                  latch_left;
  logic                  emit_valid;
  logic                  emit_err;

  logic [5:0]            bit_cnt;
  logic                  lr_prev;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [TW-1:0]         to_cnt;

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_s3 <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s    <= 1'b0;
      data_s1 <= 1'b0;
      data_s  <= 1'b0;
    end else begin
      bclk_s1 <= bclk_in;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      lr_s1   <= lrclk_in;
      lr_s    <= lr_s1;
      data_s1 <= data_in;
      data_s  <= data_s1;
    end
  end

  assign rise        = bclk_s2 & ~bclk_s3;
  assign lr_change   = rise & (lr_s != lr_prev);
  assign slot_ok     = (bit_cnt == SLOT_LAST);
  assign timeout_hit = ~rise & (to_cnt == TIMEOUT_LAST);

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (rise) begin
      to_cnt <= '0;
    end else if (to_cnt != TIMEOUT_SAT) begin
      to_cnt <= to_cnt + TIMEOUT_ONE;
    end
  end

  // The rise on an LR change carries the previous slot's LSB, so it restarts the slot instead of capturing
  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      lr_prev   <= 1'b0;
      shift_reg <= '0;
    end else if (timeout_hit) begin
      bit_cnt <= '0;
    end else if (rise) begin
      if (lr_change) begin
        bit_cnt   <= '0;
        lr_prev   <= lr_s;
        shift_reg <= '0;
      end else begin
        if (bit_cnt != CNT_MAX) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
        if (bit_cnt < CAP_LIMIT) begin
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], data_s};
        end
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      state <= UNALIGNED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    latch_left = 1'b0;
    emit_valid = 1'b0;
    emit_err   = 1'b0;
    unique case (state)
      UNALIGNED: begin
        if (lr_change) begin
          state_next = ALIGNED;
        end
      end
      ALIGNED: begin
        if (lr_change) begin
          if (!slot_ok) begin
            emit_err = 1'b1;
          end else if (!lr_prev) begin
            latch_left = 1'b1;
            state_next = HAVE_LEFT;
          end
        end
      end
      HAVE_LEFT: begin
        if (lr_change) begin
          if (!slot_ok) begin
            emit_err   = 1'b1;
            state_next = ALIGNED;
          end else if (lr_prev) begin
            emit_valid = 1'b1;
            state_next = ALIGNED;
          end else begin
            latch_left = 1'b1;
          end
        end
      end
      default: begin
        state_next = UNALIGNED;
      end
    endcase
    if (timeout_hit) begin
      state_next = UNALIGNED;
    end
  end

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg <= '0;
    end else if (latch_left) begin
      hold_reg <= shift_reg;
    end
  end

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      valid     <= emit_valid;
      frame_err <= emit_err;
      if (emit_valid) begin
        left_data  <= hold_reg;
        right_data <= shift_reg;
        locked     <= 1'b1;
      end else if (emit_err || timeout_hit) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: drives I2S frames at BCLK = CLK_IN/24 and checks
// recovered words, latency, slot errors, timeout, start-up alignment and mid-frame reset.
`timescale 1ns/1ps
module tb_i2s_slave_rx;

  localparam int DW   = 16;
  localparam int BPC  = 32;
  localparam int TO   = 256;
  localparam int HALF = 12;

  logic          CLK_IN   = 1'b0;
  logic          reset_n  = 1'b0;
  logic          bclk_in  = 1'b1;
  logic          lrclk_in = 1'b0;
  logic          data_in  = 1'b0;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          valid;
  logic          frame_err;
  logic          locked;

  int errors = 0;
  int checks = 0;

  int   valid_cnt = 0;
  int   err_cnt   = 0;
  int   wide_cnt  = 0;
  int   both_cnt  = 0;
  logic valid_q   = 1'b0;

  i2s_slave_rx #(
    .DATA_WIDTH (DW),
    .BITS_PER_CH(BPC),
    .TIMEOUT    (TO)
  ) dut (
    .CLK_IN    (CLK_IN),
    .reset_n   (reset_n),
    .bclk_in   (bclk_in),
    .lrclk_in  (lrclk_in),
    .data_in   (data_in),
    .left_data (left_data),
    .right_data(right_data),
    .valid     (valid),
    .frame_err (frame_err),
    .locked    (locked)
  );

  always #6.782 CLK_IN = ~CLK_IN;

  // Pulse bookkeeping on the inactive edge
  always @(negedge CLK_IN) begin
    if (valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (valid && valid_q) wide_cnt++;
    if (valid && frame_err) both_cnt++;
    valid_q = valid;
  end

  initial begin
    #1200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic slot_bit(input logic [DW-1:0] w, input int k);
    if (k >= 1 && k <= DW) return w[DW-k];
    return 1'b1;
  endfunction

  task automatic bit_period(input logic lr, input logic d);
    @(negedge CLK_IN);
    bclk_in  = 1'b0;
    lrclk_in = lr;
    data_in  = d;
    repeat (HALF-1) @(negedge CLK_IN);
    @(negedge CLK_IN);
    bclk_in = 1'b1;
    repeat (HALF-1) @(negedge CLK_IN);
  endtask

  task automatic send_range(input logic lr, input logic [DW-1:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) bit_period(lr, slot_bit(w, k));
  endtask

  task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int n);
    send_range(lr, w, 0, n-1);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_slot(1'b0, l, BPC);
    send_slot(1'b1, r, BPC);
  endtask

  task automatic lead_in();
    send_range(1'b0, 16'h0000, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge CLK_IN);
    reset_n  = 1'b0;
    bclk_in  = 1'b1;
    lrclk_in = 1'b0;
    data_in  = 1'b0;
    repeat (4) @(negedge CLK_IN);
    reset_n = 1'b1;
    repeat (4) @(negedge CLK_IN);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge CLK_IN);
    checks++;
    if ({left_data, right_data} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h/%h, need 0000/0000", left_data, right_data);
    end
    checks++;
    if ({valid, frame_err, locked} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got v=%b e=%b l=%b, need 0/0/0", valid, frame_err, locked);
    end
  endtask

  task automatic test_normal();
    int v0, e0;
    do_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (4) send_frame(16'h1234, 16'hABCD);
    lead_in();
    // valids at the starts of frames 3, 4 and the trailing slot
    checks++;
    if (valid_cnt - v0 !== 3) begin
      errors++;
      $display("[TB] FAIL normal_valid_count: got %0d, need 3", valid_cnt - v0);
    end
    checks++;
    if (left_data !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL normal_left: got %h, need 1234", left_data);
    end
    checks++;
    if (right_data !== 16'hABCD) begin
      errors++;
      $display("[TB] FAIL normal_right: got %h, need abcd", right_data);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL normal_locked: got %b, need 1", locked);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++;
      $display("[TB] FAIL normal_no_err: got %0d frame_err cycles, need 0", err_cnt - e0);
    end
  endtask

  // The CLK_IN period containing the BCLK rise is period 1; valid belongs in period 4,
  // i.e. it is first seen on the third negedge after the one that raised BCLK.
  task automatic test_latency();
    int n;
    do_reset();
    send_frame(16'h1234, 16'hABCD);
    send_frame(16'h1234, 16'hABCD);
    @(negedge CLK_IN);
    bclk_in  = 1'b0;
    lrclk_in = 1'b0;
    data_in  = 1'b1;
    repeat (HALF-1) @(negedge CLK_IN);
    @(negedge CLK_IN);
    bclk_in = 1'b1;
    n = 0;
    while (!valid && n < 10) begin
      @(negedge CLK_IN);
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("[TB] FAIL latency: got valid after %0d cycles, need 3 (period 4)", n);
    end
    @(negedge CLK_IN);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL valid_width: got valid=%b one cycle later, need 0", valid);
    end
    repeat (HALF) @(negedge CLK_IN);
  endtask

  task automatic test_short_slot();
    int v0, e0;
    do_reset();
    v0 = valid_cnt;
    repeat (3) send_frame(16'h1234, 16'hABCD);
    send_slot(1'b0, 16'h1234, BPC);
    checks++;
    if (valid_cnt - v0 !== 2 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_prelock: got valids=%0d locked=%b, need 2/1", valid_cnt - v0, locked);
    end
    v0 = valid_cnt;
    e0 = err_cnt;
    send_slot(1'b1, 16'hABCD, BPC-1);
    send_slot(1'b0, 16'h5A5A, BPC);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("[TB] FAIL short_err_pulse: got %0d frame_err cycles, need 1", err_cnt - e0);
    end
    checks++;
    if (valid_cnt - v0 !== 0) begin
      errors++;
      $display("[TB] FAIL short_no_valid: got %0d valids, need 0", valid_cnt - v0);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_unlock: got locked=%b, need 0", locked);
    end
    send_slot(1'b1, 16'hC3C3, BPC);
    lead_in();
    checks++;
    if (valid_cnt - v0 !== 1 || left_data !== 16'h5A5A || right_data !== 16'hC3C3 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_resume: got n=%0d %h/%h l=%b, need 1 5a5a/c3c3 1",
               valid_cnt - v0, left_data, right_data, locked);
    end
  endtask

  // Internal rise is sampled 3 cycles after BCLK rises, then TIMEOUT idle cycles drop lock
  task automatic test_timeout();
    int n, v0, e0;
    do_reset();
    repeat (3) send_frame(16'h1234, 16'hABCD);
    send_slot(1'b0, 16'h1234, BPC);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_prelock: got locked=%b, need 1", locked);
    end
    e0 = err_cnt;
    n = HALF - 1;
    while (locked && n < 400) begin
      @(negedge CLK_IN);
      n++;
    end
    checks++;
    if (n !== 3 + TO) begin
      errors++;
      $display("[TB] FAIL timeout_time: got unlock at %0d, need %0d", n, 3 + TO);
    end
    while (n < 300) begin
      @(negedge CLK_IN);
      n++;
    end
    checks++;
    if (err_cnt - e0 !== 0 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_state: got err=%0d locked=%b, need 0/0", err_cnt - e0, locked);
    end
    checks++;
    if (left_data !== 16'h1234 || right_data !== 16'hABCD) begin
      errors++;
      $display("[TB] FAIL timeout_hold: got %h/%h, need 1234/abcd", left_data, right_data);
    end
    v0 = valid_cnt;
    send_frame(16'h1111, 16'h2222);
    send_slot(1'b0, 16'h0F0F, BPC);
    checks++;
    if (valid_cnt - v0 !== 0 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_restart_quiet: got n=%0d l=%b, need 0/0", valid_cnt - v0, locked);
    end
    send_slot(1'b1, 16'hF0F0, BPC);
    lead_in();
    checks++;
    if (valid_cnt - v0 !== 1 || left_data !== 16'h0F0F || right_data !== 16'hF0F0 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_relock: got n=%0d %h/%h l=%b, need 1 0f0f/f0f0 1",
               valid_cnt - v0, left_data, right_data, locked);
    end
  endtask

  task automatic test_startup();
    int v0;
    @(negedge CLK_IN);
    reset_n = 1'b0;
    send_range(1'b1, 16'h7777, 0, 9);
    @(negedge CLK_IN);
    reset_n = 1'b1;
    v0 = valid_cnt;
    send_range(1'b1, 16'h7777, 10, BPC-1);
    send_slot(1'b0, 16'hAAAA, BPC);
    checks++;
    if (valid_cnt - v0 !== 0) begin
      errors++;
      $display("[TB] FAIL startup_quiet: got %0d valids, need 0", valid_cnt - v0);
    end
    send_slot(1'b1, 16'h5555, BPC);
    lead_in();
    checks++;
    if (valid_cnt - v0 !== 1 || left_data !== 16'hAAAA || right_data !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL startup_first_pair: got n=%0d %h/%h, need 1 aaaa/5555",
               valid_cnt - v0, left_data, right_data);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL startup_locked: got %b, need 1", locked);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    do_reset();
    repeat (3) send_frame(16'h1357, 16'h2468);
    checks++;
    if (left_data !== 16'h1357 || right_data !== 16'h2468) begin
      errors++;
      $display("[TB] FAIL midrst_pre: got %h/%h, need 1357/2468", left_data, right_data);
    end
    send_range(1'b0, 16'h1357, 0, 8);
    @(negedge CLK_IN);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({left_data, right_data, valid, frame_err, locked} !== 35'h0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got %h/%h v=%b e=%b l=%b, need all 0",
               left_data, right_data, valid, frame_err, locked);
    end
    repeat (2) @(negedge CLK_IN);
    reset_n = 1'b1;
    v0 = valid_cnt;
    send_range(1'b0, 16'h1357, 9, BPC-1);
    send_slot(1'b1, 16'h2468, BPC);
    send_slot(1'b0, 16'h3C3C, BPC);
    checks++;
    if (valid_cnt - v0 !== 0 || left_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midrst_no_stale: got n=%0d left=%h, need 0/0000", valid_cnt - v0, left_data);
    end
    send_slot(1'b1, 16'h4B4B, BPC);
    lead_in();
    checks++;
    if (valid_cnt - v0 !== 1 || left_data !== 16'h3C3C || right_data !== 16'h4B4B) begin
      errors++;
      $display("[TB] FAIL midrst_recover: got n=%0d %h/%h, need 1 3c3c/4b4b",
               valid_cnt - v0, left_data, right_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] lw [6];
    logic [DW-1:0] rw [6];
    lw = '{16'h8001, 16'h0001, 16'hFFFF, 16'h0000, 16'h7E81, 16'h1234};
    rw = '{16'h4002, 16'h8000, 16'h0000, 16'hFFFF, 16'h8118, 16'hFEDC};
    do_reset();
    send_frame(lw[0], rw[0]);
    send_frame(lw[1], rw[1]);
    for (int k = 1; k <= 4; k++) begin
      send_slot(1'b0, lw[k+1], BPC);
      checks++;
      if (left_data !== lw[k]) begin
        errors++;
        $display("[TB] FAIL b2b_left[%0d]: got %h, need %h", k, left_data, lw[k]);
      end
      checks++;
      if (right_data !== rw[k]) begin
        errors++;
        $display("[TB] FAIL b2b_right[%0d]: got %h, need %h", k, right_data, rw[k]);
      end
      send_slot(1'b1, rw[k+1], BPC);
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (wide_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL valid_single_cycle: got %0d over-long valid cycles, need 0", wide_cnt);
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL valid_err_exclusive: got %0d overlap cycles, need 0", both_cnt);
    end
  endtask

  initial begin
    $display("[TB] i2s_slave_rx directed bench start");
    test_reset();
    test_normal();
    test_latency();
    test_short_slot();
    test_timeout();
    test_startup();
    test_reset_mid_frame();
    test_back_to_back();
    test_pulse_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
